tc_cheap_ram_requester: RTL and testbench



---
 rtl/tc_ram_req_pkg.sv | 17 +
 rtl/tc_cheap_ram_requester_if.sv | 47 ++++
 rtl/tc_ram_line_buf.sv | 53 +++++
 rtl/tc_cheap_ram_requester.sv | 190 +++++++++++++++++++
 tb/tb_tc_cheap_ram_requester.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/tc_ram_req_pkg.sv
// Shared types and geometry for the cheap-RAM requester.
package tc_ram_req_pkg;

    localparam int unsigned ADDR_BITS   = 16;
    localparam int unsigned LINE_WORDS  = 4;
    localparam int unsigned OFFSET_BITS = 2;
    localparam int unsigned TAG_BITS    = ADDR_BITS - OFFSET_BITS;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_SAVE,
        ST_RESP
    } state_e;

endpackage

// File: rtl/tc_cheap_ram_requester_if.sv
// CPU data port plus cheap-RAM initiator port, bundled as one interface.
interface tc_cheap_ram_requester_if #(
    parameter int unsigned BIT_WIDTH = 16
);
    import tc_ram_req_pkg::*;

    logic                 req_valid;
    logic                 req_write;
    logic [ADDR_BITS-1:0] req_addr;
    logic [BIT_WIDTH-1:0] req_wdata;
    logic                 req_ready;
    logic                 rsp_valid;
    logic [BIT_WIDTH-1:0] rsp_rdata;
    logic                 rsp_err;

    logic                 mem_load;
    logic                 mem_save;
    logic [ADDR_BITS-1:0] mem_address;
    logic [BIT_WIDTH-1:0] mem_in0;
    logic [BIT_WIDTH-1:0] mem_in1;
    logic [BIT_WIDTH-1:0] mem_in2;
    logic [BIT_WIDTH-1:0] mem_in3;
    logic                 mem_ready;
    logic [BIT_WIDTH-1:0] mem_out0;
    logic [BIT_WIDTH-1:0] mem_out1;
    logic [BIT_WIDTH-1:0] mem_out2;
    logic [BIT_WIDTH-1:0] mem_out3;

    // Requester side: serves the CPU, drives the RAM.
    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_load, mem_save, mem_address,
        output mem_in0, mem_in1, mem_in2, mem_in3,
        input  mem_ready, mem_out0, mem_out1, mem_out2, mem_out3
    );

    // Environment side: CPU and RAM.
    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_load, mem_save, mem_address,
        input  mem_in0, mem_in1, mem_in2, mem_in3,
        output mem_ready, mem_out0, mem_out1, mem_out2, mem_out3
    );

endinterface

// File: rtl/tc_ram_line_buf.sv
// Single-line buffer: valid/tag/words, hit compare, word read mux, fill and word-merge ports.
module tc_ram_line_buf
    import tc_ram_req_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 inval,
    input  logic                                 fill_en,
    input  logic [TAG_BITS-1:0]                  fill_tag,
    input  logic [LINE_WORDS-1:0][BIT_WIDTH-1:0] fill_line,
    input  logic                                 wr_en,
    input  logic [OFFSET_BITS-1:0]               wr_sel,
    input  logic [BIT_WIDTH-1:0]                 wr_data,
    input  logic [TAG_BITS-1:0]                  look_tag,
    input  logic [OFFSET_BITS-1:0]               look_sel,
    output logic                                 hit_c,
    output logic [BIT_WIDTH-1:0]                 rd_word_c,
    output logic [LINE_WORDS-1:0][BIT_WIDTH-1:0] line_c
);

    logic                                 valid_q;
    logic [TAG_BITS-1:0]                  tag_q;
    logic [LINE_WORDS-1:0][BIT_WIDTH-1:0] words_q;

    // Fill loads a whole line; a word write in the same cycle overrides its lane.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            words_q <= '0;
        end else begin
            if (inval) begin
                valid_q <= 1'b0;
            end else if (fill_en) begin
                valid_q <= 1'b1;
                tag_q   <= fill_tag;
            end
            if (fill_en) begin
                words_q <= fill_line;
            end
            if (wr_en) begin
                words_q[wr_sel] <= wr_data;
            end
        end
    end

    assign hit_c     = valid_q && (tag_q == look_tag);
    assign rd_word_c = words_q[look_sel];
    assign line_c    = words_q;

endmodule

// File: rtl/tc_cheap_ram_requester.sv
// Turns single-word CPU loads/stores into line load/save transactions on the cheap RAM.
module tc_cheap_ram_requester
    import tc_ram_req_pkg::*;
#(
    parameter int unsigned BIT_WIDTH = 16,
    parameter int unsigned TIMEOUT   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    tc_cheap_ram_requester_if.master bus
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT);

    typedef logic [LINE_WORDS-1:0][BIT_WIDTH-1:0] line_t;

    function automatic line_t merge_word(line_t line, logic [OFFSET_BITS-1:0] sel,
                                         logic [BIT_WIDTH-1:0] data);
        line_t m;
        m      = line;
        m[sel] = data;
        return m;
    endfunction

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 write_q, write_d;
    logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
    logic                 req_ready_q, req_ready_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [BIT_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 mem_load_q, mem_load_d;
    logic                 mem_save_q, mem_save_d;
    logic [ADDR_BITS-1:0] mem_address_q, mem_address_d;
    line_t                mem_in_q, mem_in_d;

    logic                   fill_en_c, wr_en_c, inval_c, hit_c;
    logic [OFFSET_BITS-1:0] wr_sel_c;
    logic [BIT_WIDTH-1:0]   wr_data_c, buf_word_c;
    line_t                  buf_line_c, mem_out_c;

    assign mem_out_c = {bus.mem_out3, bus.mem_out2, bus.mem_out1, bus.mem_out0};

    tc_ram_line_buf #(.BIT_WIDTH(BIT_WIDTH)) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .inval     (inval_c),
        .fill_en   (fill_en_c),
        .fill_tag  (addr_q[ADDR_BITS-1:OFFSET_BITS]),
        .fill_line (mem_out_c),
        .wr_en     (wr_en_c),
        .wr_sel    (wr_sel_c),
        .wr_data   (wr_data_c),
        .look_tag  (bus.req_addr[ADDR_BITS-1:OFFSET_BITS]),
        .look_sel  (bus.req_addr[OFFSET_BITS-1:0]),
        .hit_c     (hit_c),
        .rd_word_c (buf_word_c),
        .line_c    (buf_line_c)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            addr_q        <= '0;
            write_q       <= 1'b0;
            wdata_q       <= '0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_load_q    <= 1'b0;
            mem_save_q    <= 1'b0;
            mem_address_q <= '0;
            mem_in_q      <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_q        <= addr_d;
            write_q       <= write_d;
            wdata_q       <= wdata_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_err_q     <= rsp_err_d;
            rsp_rdata_q   <= rsp_rdata_d;
            mem_load_q    <= mem_load_d;
            mem_save_q    <= mem_save_d;
            mem_address_q <= mem_address_d;
            mem_in_q      <= mem_in_d;
        end
    end

    // Next state, next outputs and line-buffer control.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        write_d       = write_q;
        wdata_d       = wdata_q;
        rsp_err_d     = 1'b0;
        rsp_rdata_d   = '0;
        mem_load_d    = 1'b0;
        mem_save_d    = 1'b0;
        mem_address_d = mem_address_q;
        mem_in_d      = mem_in_q;
        fill_en_c     = 1'b0;
        wr_en_c       = 1'b0;
        inval_c       = 1'b0;
        wr_sel_c      = addr_q[OFFSET_BITS-1:0];
        wr_data_c     = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    addr_d        = bus.req_addr;
                    write_d       = bus.req_write;
                    wdata_d       = bus.req_wdata;
                    mem_address_d = {bus.req_addr[ADDR_BITS-1:OFFSET_BITS], OFFSET_BITS'(0)};
                    if (hit_c && !bus.req_write) begin
                        rsp_rdata_d = buf_word_c;
                        state_d     = ST_RESP;
                    end else if (hit_c) begin
                        wr_en_c    = 1'b1;
                        wr_sel_c   = bus.req_addr[OFFSET_BITS-1:0];
                        wr_data_c  = bus.req_wdata;
                        mem_in_d   = merge_word(buf_line_c, bus.req_addr[OFFSET_BITS-1:0],
                                                bus.req_wdata);
                        mem_save_d = 1'b1;
                        state_d    = ST_WR_SAVE;
                    end else begin
                        mem_load_d = 1'b1;
                        state_d    = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                cnt_d   = '0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (bus.mem_ready) begin
                    fill_en_c = 1'b1;
                    if (write_q) begin
                        wr_en_c    = 1'b1;
                        mem_in_d   = merge_word(mem_out_c, addr_q[OFFSET_BITS-1:0], wdata_q);
                        mem_save_d = 1'b1;
                        state_d    = ST_WR_SAVE;
                    end else begin
                        rsp_rdata_d = mem_out_c[addr_q[OFFSET_BITS-1:0]];
                        state_d     = ST_RESP;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    inval_c   = 1'b1;
                    rsp_err_d = 1'b1;
                    state_d   = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_SAVE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rsp_valid_d = (state_d == ST_RESP);
        req_ready_d = (state_d == ST_IDLE);
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.mem_load    = mem_load_q;
    assign bus.mem_save    = mem_save_q;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_in0     = mem_in_q[0];
    assign bus.mem_in1     = mem_in_q[1];
    assign bus.mem_in2     = mem_in_q[2];
    assign bus.mem_in3     = mem_in_q[3];

endmodule

// File: tb/tb_tc_cheap_ram_requester.sv
// Randomised bench for tc_cheap_ram_requester with a cheap-RAM responder and a line-level reference model.
module tb_tc_cheap_ram_requester;

    localparam int unsigned BW = 16;
    localparam int unsigned TO = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tc_cheap_ram_requester_if #(.BIT_WIDTH(BW)) bus();

    tc_cheap_ram_requester #(.BIT_WIDTH(BW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // RAM responder: 64 words, ready lat cycles after the load strobe, save on falling edge.
    logic [15:0] ram     [64];
    logic [15:0] ref_mem [64];
    bit          preload   = 1'b1;
    bit          pend      = 1'b0;
    int          dly       = 0;
    logic [15:0] laddr     = '0;
    int          ram_lat   = 2;
    bit          ram_never = 1'b0;

    always @(posedge clk) begin
        if (bus.mem_load) begin
            pend  <= 1'b1;
            dly   <= ram_lat - 1;
            laddr <= bus.mem_address;
        end else if (pend) begin
            if (dly > 0) dly <= dly - 1;
            else if (!ram_never) pend <= 1'b0;
        end
    end

    assign bus.mem_ready = pend && (dly == 0) && !ram_never;
    assign bus.mem_out0  = ram[{laddr[5:2], 2'd0}];
    assign bus.mem_out1  = ram[{laddr[5:2], 2'd1}];
    assign bus.mem_out2  = ram[{laddr[5:2], 2'd2}];
    assign bus.mem_out3  = ram[{laddr[5:2], 2'd3}];

    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) ram[i] <= ref_mem[i];
        end else if (bus.mem_save) begin
            ram[{bus.mem_address[5:2], 2'd0}] <= bus.mem_in0;
            ram[{bus.mem_address[5:2], 2'd1}] <= bus.mem_in1;
            ram[{bus.mem_address[5:2], 2'd2}] <= bus.mem_in2;
            ram[{bus.mem_address[5:2], 2'd3}] <= bus.mem_in3;
        end
    end

    // Reference model: which line the requester should be holding.
    bit          ref_valid = 1'b0;
    logic [13:0] ref_tag   = '0;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        @(negedge clk);
        while (bus.req_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("req_ready_before_req", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic do_req(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                          input int lat, input bit never);
        bit          hit, tmo, got;
        int          cyc, n_load, n_save, ld_cyc, exp_cyc;
        logic [15:0] base, ld_addr, sv_addr, rd;
        logic        err;
        logic [15:0] sv [4];
        hit     = ref_valid && (ref_tag == addr[15:2]);
        tmo     = !hit && never;
        base    = {addr[15:2], 2'b00};
        got     = 1'b0;
        n_load  = 0;
        n_save  = 0;
        ld_cyc  = 0;
        ld_addr = '0;
        sv_addr = '0;
        rd      = '0;
        err     = 1'b0;
        for (int i = 0; i < 4; i++) sv[i] = '0;
        ram_lat   = lat;
        ram_never = never;

        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_wdata = '0;

        cyc = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.mem_load) begin
                n_load++;
                ld_cyc  = cyc;
                ld_addr = bus.mem_address;
            end
            if (bus.mem_save) begin
                n_save++;
                sv_addr = bus.mem_address;
                sv[0] = bus.mem_in0;
                sv[1] = bus.mem_in1;
                sv[2] = bus.mem_in2;
                sv[3] = bus.mem_in3;
            end
            if (bus.rsp_valid) begin
                got = 1'b1;
                rd  = bus.rsp_rdata;
                err = bus.rsp_err;
            end
        end
        check_eq("rsp_valid_seen", 32'(got), 32'd1);

        if (hit)      exp_cyc = wr ? 2 : 1;
        else if (tmo) exp_cyc = 2 + TO;
        else          exp_cyc = 2 + lat + (wr ? 1 : 0);

        if (tmo) begin
            ref_valid = 1'b0;
        end else begin
            ref_valid = 1'b1;
            ref_tag   = addr[15:2];
            if (wr) ref_mem[addr[5:0]] = wd;
        end

        check_eq("rsp_cycle", 32'(cyc), 32'(exp_cyc));
        check_eq("rsp_err", 32'(err), 32'(tmo));
        check_eq("rsp_rdata", 32'(rd), (wr || tmo) ? 32'd0 : 32'(ref_mem[addr[5:0]]));
        check_eq("mem_load_count", 32'(n_load), hit ? 32'd0 : 32'd1);
        check_eq("mem_save_count", 32'(n_save), (wr && !tmo) ? 32'd1 : 32'd0);
        if (n_load == 1) begin
            check_eq("mem_load_cycle", 32'(ld_cyc), 32'd1);
            check_eq("mem_load_addr", 32'(ld_addr), 32'(base));
        end
        if (n_save == 1) begin
            check_eq("mem_save_addr", 32'(sv_addr), 32'(base));
            for (int i = 0; i < 4; i++)
                check_eq("mem_in_word", 32'(sv[i]), 32'(ref_mem[{base[5:2], 2'(i)}]));
        end
    endtask

    // Reset lands in RD_WAIT; the late RAM ready must be ignored and no response produced.
    task automatic reset_mid_test(input logic [15:0] addr);
        int n_rsp;
        n_rsp     = 0;
        ram_lat   = 4;
        ram_never = 1'b0;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = addr;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check_eq("rst_mid_mem_load", 32'(bus.mem_load), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_mid_req_ready_low", 32'(bus.req_ready), 32'd0);
        if (bus.rsp_valid) n_rsp++;
        @(negedge clk);
        check_eq("rst_mid_req_ready_high", 32'(bus.req_ready), 32'd1);
        if (bus.rsp_valid) n_rsp++;
        for (int c = 5; c <= 12; c++) begin
            @(negedge clk);
            if (bus.rsp_valid) n_rsp++;
        end
        check_eq("rst_mid_no_rsp", 32'(n_rsp), 32'd0);
        ref_valid = 1'b0;
        ram_lat   = 2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] last;
        bit          wr, nv;
        logic [15:0] a;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) begin
            ref_mem[16 + i] = 16'hA000 + 16'(i);
            ref_mem[32 + i] = 16'hB000 + 16'(i);
        end

        @(negedge clk);
        check_eq("reset_req_ready", 32'(bus.req_ready), 32'd0);
        check_eq("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        check_eq("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check_eq("reset_mem_load", 32'(bus.mem_load), 32'd0);
        check_eq("reset_mem_save", 32'(bus.mem_save), 32'd0);
        check_eq("reset_mem_address", 32'(bus.mem_address), 32'd0);
        check_eq("reset_mem_in0", 32'(bus.mem_in0), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        preload = 1'b0;
        @(negedge clk);
        check_eq("post_reset_req_ready", 32'(bus.req_ready), 32'd1);

        do_req(1'b0, 16'h0012, 16'h0000, 2, 1'b0);
        do_req(1'b0, 16'h0013, 16'h0000, 2, 1'b0);
        do_req(1'b1, 16'h0021, 16'h1234, 2, 1'b0);
        do_req(1'b0, 16'h0021, 16'h0000, 2, 1'b0);
        do_req(1'b0, 16'h0030, 16'h0000, 2, 1'b1);
        do_req(1'b0, 16'h0030, 16'h0000, 2, 1'b0);
        reset_mid_test(16'h0005);
        do_req(1'b0, 16'h0005, 16'h0000, 2, 1'b0);

        last = 16'h0005;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 1) == 0) a = {last[15:2], 2'($urandom)};
            else                           a = 16'($urandom_range(0, 63));
            wr = 1'($urandom);
            nv = ($urandom_range(0, 9) == 0);
            do_req(wr, a, 16'($urandom), int'($urandom_range(2, 5)), nv);
            last = a;
        end

        repeat (3) @(negedge clk);
        for (int i = 0; i < 64; i++) check_eq("ram_contents", 32'(ram[i]), 32'(ref_mem[i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
